stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM for the chained BCD digit counters of the stopwatch/timer.
//  Turns single-cycle button pulses into digit-counter controls:
//   - a prescaled count tick to the least-significant digit
//   - a direction select (count up or count down)
//   - a clear strobe
//   - per-digit preset load strobes
//  Detects terminal count and reports done. Sits between the button debouncers and the digit datapath.
// PARAMETERS
//  TICK_DIV  100000  clk cycles per count tick (>=2)
//  NDIG      4       number of BCD digits in the chain (1..8)
// PORTS
//  clk        in   1     system clock
//  reset      in   1     asynchronous, active-high reset
//  btn_start  in   1     1-cycle pulse; start/pause toggle
//  btn_clear  in   1     1-cycle pulse; abort to IDLE and clear counters
//  btn_set    in   1     1-cycle pulse; enter/leave preset (SET) state
//  btn_inc    in   1     1-cycle pulse; increment selected preset digit
//  btn_next   in   1     1-cycle pulse; select next preset digit
//  mode_up    in   1     level; 1 = count up (stopwatch), 0 = count down (timer)
//  cnt_zero   in   1     datapath flag; all digits == 0
//  cnt_max    in   1     datapath flag; all digits == 9
//  tick_en    out  1     1-cycle count enable to the LSD counter
//  cnt_up     out  1     latched direction to all digit counters
//  cnt_clr    out  1     1-cycle clear strobe to all digits
//  load_en    out  1     1-cycle preset load strobe
//  load_sel   out  NDIG  one-hot digit select; 0 outside SET
//  load_val   out  4     BCD preset value, 0..9
//  running    out  1     high in RUN
//  setting    out  1     high in SET
//  done       out  1     high in DONE
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; prescaler=0; pointer=0; shadow digits=0; cnt_up=1; all other outputs=0.
//  - All outputs are registered; each pulse appears the cycle after the edge that sampled its cause.
//  - Pulse priority when several are high together: clear > set > start > next > inc. Lower-priority pulses are dropped.
//  - btn_clear, any state: go to IDLE; cnt_clr=1 for one cycle; prescaler=0; shadow digits=0.
//  - IDLE:
//     - cnt_up follows mode_up every cycle. cnt_up is frozen in every other state, so a mode change outside IDLE is ignored.
//     - btn_start -> RUN with prescaler=0, unless mode_up=0 and cnt_zero=1 (then ignored).
//     - btn_set -> SET only if mode_up=0; ignored in up mode.
//  - RUN:
//     - Prescaler counts 0..TICK_DIV-1 and wraps.
//     - At prescaler==TICK_DIV-1: if (cnt_up & cnt_max) | (~cnt_up & cnt_zero), go to DONE with no tick; otherwise tick_en=1 next cycle.
//     - First tick is exactly TICK_DIV cycles after the start edge.
//     - btn_start -> PAUSE.
//  - PAUSE: prescaler holds its value; btn_start -> RUN and the prescaler resumes from the held value.
//  - SET:
//     - load_sel = onehot(ptr), ptr starts at 0 (LSD).
//     - btn_next: ptr = ptr+1, wrapping NDIG-1 -> 0.
//     - btn_inc: shadow[ptr] = (shadow[ptr]==9) ? 0 : shadow[ptr]+1; next cycle load_en=1 and load_val=new shadow[ptr].
//     - btn_set -> IDLE; shadow digits retained.
//  - DONE: done=1, tick_en=0; btn_start -> IDLE with no clear; btn_clear -> IDLE with clear.
//  - Reset while in RUN or SET: the in-flight tick or load is discarded.
// TESTING (bench with TICK_DIV=4, NDIG=2)
//  1. Reset mid-RUN -> next cycle all outputs 0, cnt_up=1, running=0; no further tick_en.
//  2. mode_up=1, btn_start -> tick_en on cycles 4, 8, 12 after start. btn_start at cycle 6 -> no ticks.
//     btn_start again -> next tick 2 cycles after resume.
//  3. mode_up=0, btn_set, btn_inc x3, btn_next, btn_inc -> load_en with (load_sel,load_val) = (01,1), (01,2), (01,3), (10,1).
//     btn_set -> setting=0.
//  4. Down RUN with cnt_zero=1 before a tick point -> no tick_en, done=1 next cycle. btn_start -> IDLE, done=0, cnt_clr=0.
//  5. btn_clear and btn_start in the same cycle during RUN -> IDLE, cnt_clr=1 for one cycle, no tick_en afterwards.
//  6. Toggle mode_up during RUN and PAUSE -> cnt_up unchanged. After btn_clear -> cnt_up tracks mode_up again.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Purpose: button/flag inputs and digit-counter controls of the stopwatch controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; all controls are single-cycle strobes or levels.
// Ports (master = button/datapath side, slave = stopwatch_ctrl):
//   btn_start/btn_clear/btn_set/btn_inc/btn_next  1-cycle button pulses
//   mode_up (level), cnt_zero / cnt_max (datapath flags)
//   tick_en, cnt_up, cnt_clr, load_en, load_sel[NDIG], load_val[4], running, setting, done
interface stopwatch_ctrl_if #(
    parameter int NDIG = 4
);
    logic            btn_start;
    logic            btn_clear;
    logic            btn_set;
    logic            btn_inc;
    logic            btn_next;
    logic            mode_up;
    logic            cnt_zero;
    logic            cnt_max;
    logic            tick_en;
    logic            cnt_up;
    logic            cnt_clr;
    logic            load_en;
    logic [NDIG-1:0] load_sel;
    logic [3:0]      load_val;
    logic            running;
    logic            setting;
    logic            done;

    modport master (
        output btn_start, btn_clear, btn_set, btn_inc, btn_next,
               mode_up, cnt_zero, cnt_max,
        input  tick_en, cnt_up, cnt_clr, load_en, load_sel, load_val,
               running, setting, done
    );

    modport slave (
        input  btn_start, btn_clear, btn_set, btn_inc, btn_next,
               mode_up, cnt_zero, cnt_max,
        output tick_en, cnt_up, cnt_clr, load_en, load_sel, load_val,
               running, setting, done
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: control FSM turning button pulses into prescaled ticks, clear/preset strobes and done.
// Latency: every output is registered; a strobe appears one cycle after the edge sampling its cause.
// Backpressure: none; simultaneous pulses resolve clear > set > start > next > inc, losers dropped.
// Ports: clk, reset (async, active-high); bus = stopwatch_ctrl_if.slave (buttons, mode_up,
//        cnt_zero/cnt_max in; tick_en, cnt_up, cnt_clr, load_en/sel/val, running/setting/done out).
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int NDIG     = 4
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   bus
);
    localparam int PSW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PW  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PSW-1:0] PMAX = PSW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PLAST = PW'(NDIG - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        SET   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      shadow_q [NDIG];
    logic [3:0]      shadow_d [NDIG];
    logic            cnt_up_q, cnt_up_d;
    logic            tick_q, tick_d;
    logic            clr_q, clr_d;
    logic            load_q, load_d;
    logic [NDIG-1:0] sel_q, sel_d;
    logic [3:0]      val_q, val_d;
    logic            running_q, setting_q, done_q;

    // Priority-resolved pulses; only one of these can be high in a cycle.
    logic take_clear, take_set, take_start, take_next, take_inc;
    logic wrap, term;

    always_comb begin
        take_clear = bus.btn_clear;
        take_set   = !bus.btn_clear && bus.btn_set;
        take_start = !bus.btn_clear && !bus.btn_set && bus.btn_start;
        take_next  = !bus.btn_clear && !bus.btn_set && !bus.btn_start && bus.btn_next;
        take_inc   = !bus.btn_clear && !bus.btn_set && !bus.btn_start && !bus.btn_next
                     && bus.btn_inc;
        wrap       = (presc_q == PMAX);
        // Terminal count is judged in the direction latched at start, not the live mode.
        term       = cnt_up_q ? bus.cnt_max : bus.cnt_zero;

        state_d  = state_q;
        presc_d  = presc_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;
        cnt_up_d = cnt_up_q;
        tick_d   = 1'b0;
        clr_d    = 1'b0;
        load_d   = 1'b0;
        val_d    = 4'd0;

        if (state_q == IDLE) begin
            cnt_up_d = bus.mode_up;
        end

        if (take_clear) begin
            state_d  = IDLE;
            clr_d    = 1'b1;
            presc_d  = '0;
            shadow_d = '{default: 4'd0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_set && !bus.mode_up) begin
                        state_d = SET;
                        ptr_d   = '0;
                    end else if (take_start && !(!bus.mode_up && bus.cnt_zero)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // The prescaler keeps counting on the pausing edge; PAUSE then holds it.
                    presc_d = wrap ? '0 : presc_q + PSW'(1);
                    if (take_start) begin
                        state_d = PAUSE;
                        tick_d  = wrap && !term;
                    end else if (wrap && term) begin
                        state_d = DONE;
                    end else begin
                        tick_d  = wrap;
                    end
                end
                PAUSE: begin
                    if (take_start) begin
                        state_d = RUN;
                    end
                end
                SET: begin
                    if (take_set) begin
                        state_d = IDLE;
                    end else if (take_next) begin
                        ptr_d = (ptr_q == PLAST) ? '0 : ptr_q + PW'(1);
                    end else if (take_inc) begin
                        shadow_d[ptr_q] = (shadow_q[ptr_q] == 4'd9) ? 4'd0
                                                                    : shadow_q[ptr_q] + 4'd1;
                        load_d = 1'b1;
                        val_d  = shadow_d[ptr_q];
                    end
                end
                DONE: begin
                    if (take_start) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sel_d = (state_d == SET) ? (NDIG'(1) << ptr_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ptr_q     <= '0;
            shadow_q  <= '{default: 4'd0};
            cnt_up_q  <= 1'b1;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
            load_q    <= 1'b0;
            sel_q     <= '0;
            val_q     <= 4'd0;
            running_q <= 1'b0;
            setting_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            cnt_up_q  <= cnt_up_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
            val_q     <= val_d;
            running_q <= (state_d == RUN);
            setting_q <= (state_d == SET);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.tick_en  = tick_q;
    assign bus.cnt_up   = cnt_up_q;
    assign bus.cnt_clr  = clr_q;
    assign bus.load_en  = load_q;
    assign bus.load_sel = sel_q;
    assign bus.load_val = val_q;
    assign bus.running  = running_q;
    assign bus.setting  = setting_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose: scoreboard bench for stopwatch_ctrl with TICK_DIV=4, NDIG=2.
// Latency: expected outputs are queued per clock and compared one edge later.
// Backpressure: none.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.NDIG(ND)) bus ();

    stopwatch_ctrl #(.TICK_DIV(TD), .NDIG(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Output vector: tick, cnt_up, clr, load_en, load_sel[2], load_val[4], running, setting, done
    typedef logic [12:0] outv_t;
    outv_t expq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    // Stimulus for the next edge
    logic s_reset = 1'b1;
    logic s_start = 0, s_clear = 0, s_set = 0, s_inc = 0, s_next = 0;
    logic s_mode = 1, s_zero = 0, s_max = 0;

    // Behavioural model: mode names, elapsed count within the current tick period,
    // selected digit, preset digits as plain ints, latched direction.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SET = 3, M_DONE = 4;
    int m_mode  = M_IDLE;
    int m_elap  = 0;
    int m_dig   = 0;
    int m_pre [ND];
    bit m_up    = 1;

    task automatic model_step(output outv_t e);
        bit tick = 0, clr = 0, ld = 0;
        int lv = 0;
        string win;
        int sel;
        if (s_reset) begin
            m_mode = M_IDLE; m_elap = 0; m_dig = 0; m_up = 1;
            foreach (m_pre[i]) m_pre[i] = 0;
        end else begin
            win = s_clear ? "clear" : s_set ? "set" : s_start ? "start" :
                  s_next ? "next" : s_inc ? "inc" : "none";
            if (m_mode == M_IDLE) m_up = s_mode;
            if (win == "clear") begin
                m_mode = M_IDLE; clr = 1; m_elap = 0;
                foreach (m_pre[i]) m_pre[i] = 0;
            end else if (m_mode == M_IDLE) begin
                if (win == "set" && !s_mode) begin
                    m_mode = M_SET; m_dig = 0;
                end else if (win == "start" && (s_mode || !s_zero)) begin
                    m_mode = M_RUN; m_elap = 0;
                end
            end else if (m_mode == M_RUN) begin
                bit period_end = (m_elap == TD - 1);
                bit at_end = m_up ? s_max : s_zero;
                m_elap = (m_elap + 1) % TD;
                if (win == "start") begin
                    m_mode = M_PAUSE;
                    tick = period_end && !at_end;
                end else if (period_end && at_end) begin
                    m_mode = M_DONE;
                end else begin
                    tick = period_end;
                end
            end else if (m_mode == M_PAUSE) begin
                if (win == "start") m_mode = M_RUN;
            end else if (m_mode == M_SET) begin
                if (win == "set") m_mode = M_IDLE;
                else if (win == "next") m_dig = (m_dig + 1) % ND;
                else if (win == "inc") begin
                    m_pre[m_dig] = (m_pre[m_dig] + 1) % 10;
                    ld = 1; lv = m_pre[m_dig];
                end
            end else if (m_mode == M_DONE) begin
                if (win == "start") m_mode = M_IDLE;
            end
        end
        sel = (m_mode == M_SET) ? (1 << m_dig) : 0;
        e = {tick, m_up, clr, ld, 2'(sel), 4'(lv),
             (m_mode == M_RUN), (m_mode == M_SET), (m_mode == M_DONE)};
    endtask

    task automatic step();
        outv_t e;
        @(negedge clk);
        #1;
        reset         = s_reset;
        bus.btn_start = s_start;
        bus.btn_clear = s_clear;
        bus.btn_set   = s_set;
        bus.btn_inc   = s_inc;
        bus.btn_next  = s_next;
        bus.mode_up   = s_mode;
        bus.cnt_zero  = s_zero;
        bus.cnt_max   = s_max;
        model_step(e);
        expq.push_back(e);
        s_start = 0; s_clear = 0; s_set = 0; s_inc = 0; s_next = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every clock the DUT presents a fresh registered output vector.
    initial begin : monitor
        outv_t exp_v, act;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                act = {bus.tick_en, bus.cnt_up, bus.cnt_clr, bus.load_en, bus.load_sel,
                       bus.load_val, bus.running, bus.setting, bus.done};
                n_checks++;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs(tick,up,clr,ld,sel,val,run,set,done) cycle %0d: actual %b required %b",
                             cyc, act, exp_v);
                end
            end
        end
    end

    initial begin
        bus.btn_start = 0; bus.btn_clear = 0; bus.btn_set = 0; bus.btn_inc = 0;
        bus.btn_next = 0; bus.mode_up = 1; bus.cnt_zero = 0; bus.cnt_max = 0;

        // Reset state, then reset in the middle of RUN
        idle(3);
        s_reset = 0; s_mode = 1;
        idle(2);
        s_start = 1; step();
        idle(5);
        s_reset = 1; step();
        s_reset = 0; idle(6);

        // Up count: ticks every TD cycles, pause at cycle 6, resume
        s_start = 1; step();
        idle(5);
        s_start = 1; step();
        idle(4);
        s_start = 1; step();
        idle(10);
        s_clear = 1; step();
        idle(2);

        // Preset entry in down mode, including set ignored in up mode
        s_set = 1; step();
        s_mode = 0; idle(1);
        s_set = 1; step();
        for (int i = 0; i < 3; i++) begin s_inc = 1; step(); end
        s_next = 1; step();
        s_inc = 1; step();
        s_next = 1; s_inc = 1; step();
        s_set = 1; step();
        idle(2);

        // Down count reaching zero -> DONE, start leaves without clear
        s_start = 1; step();
        idle(5);
        s_zero = 1; idle(4);
        s_start = 1; step();
        s_start = 1; step();
        idle(2);
        s_zero = 0;

        // Clear and start together during RUN
        s_mode = 1; idle(1);
        s_start = 1; step();
        idle(3);
        s_clear = 1; s_start = 1; step();
        idle(6);

        // Mode toggles in RUN and PAUSE are ignored; IDLE tracks again after clear
        s_start = 1; step();
        s_mode = 0; idle(3);
        s_start = 1; s_mode = 1; step();
        s_mode = 0; idle(3);
        s_clear = 1; step();
        idle(2);
        s_mode = 1; idle(2);
        s_mode = 0; idle(2);
        s_max = 1; s_mode = 1; s_start = 1; step();
        idle(5);
        s_max = 0;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            s_reset = ($urandom_range(0, 299) == 0);
            s_start = ($urandom_range(0, 7) == 0);
            s_clear = ($urandom_range(0, 39) == 0);
            s_set   = ($urandom_range(0, 11) == 0);
            s_inc   = ($urandom_range(0, 3) == 0);
            s_next  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) s_mode = ~s_mode;
            s_zero  = ($urandom_range(0, 5) == 0);
            s_max   = ($urandom_range(0, 5) == 0);
            step();
        end
        s_reset = 0;
        idle(2);

        repeat (3) @(negedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
